// File: rtl/mem_boot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_boot_arbiter_pkg
// Shared constants for the boot sequencer / memory arbiter slice.
//   - FSM state encodings (3 bits, values are visible on state_o)
//   - default memory geometry (AW/DW)
//   - hold-delay counter sizing
// -----------------------------------------------------------------------------
package mem_boot_arbiter_pkg;

    localparam int AW_DEF       = 5;   // 32 memory locations
    localparam int DW_DEF       = 8;   // byte-wide memory
    localparam int HOLD_CYC_MAX = 15;  // largest supported reset hold delay
    localparam int HOLD_CNT_W   = 4;   // wide enough for HOLD_CYC_MAX

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_LOAD = 3'd1;
    localparam state_t ST_HOLD = 3'd2;
    localparam state_t ST_RUN  = 3'd3;
    localparam state_t ST_HALT = 3'd4;

endpackage

// File: rtl/mem_boot_arbiter_mem_port_mux.sv
// -----------------------------------------------------------------------------
// mem_port_mux
// Combinational select of the single memory port between the external loader
// and the CPU core.
//   state                      : current boot FSM state
//   ewr/ead/edat               : loader write strobe, address, data
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata/cpu_halt         : CPU request side
//   mem_we/mem_addr/mem_wdata  : memory port
//   cpu_gnt                    : CPU request accepted this cycle
//   ld_wr                      : loader write performed this cycle (for counting)
//
// Handshake: cpu_req is a valid, cpu_gnt is the ready. A transfer happens in
// the cycle where both are high; a request that sees cpu_gnt=0 must be held
// unchanged by the CPU until it is granted.
// -----------------------------------------------------------------------------
module mem_port_mux
    import mem_boot_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  state_t        state,
    input  logic          ewr,
    input  logic [AW-1:0] ead,
    input  logic [DW-1:0] edat,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halt,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          cpu_gnt,
    output logic          ld_wr
);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_gnt   = 1'b0;
        ld_wr     = 1'b0;
        case (state)
            ST_LOAD, ST_HALT: begin
                if (ewr) begin
                    mem_we    = 1'b1;
                    mem_addr  = ead;
                    mem_wdata = edat;
                    ld_wr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (ewr) begin
                    // Fixed loader priority: the CPU simply retries next cycle.
                    mem_we    = 1'b1;
                    mem_addr  = ead;
                    mem_wdata = edat;
                    ld_wr     = 1'b1;
                end else begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    // A halting CPU gets nothing, even in the cycle halt rises.
                    cpu_gnt   = cpu_req & ~cpu_halt;
                    mem_we    = cpu_gnt & cpu_we;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// mem_boot_arbiter
// Boot sequencer and memory arbiter. Holds the CPU in reset while the loader
// writes a program image, releases it HOLD_CYC cycles after ld_done, then
// shares the memory between loader (priority) and CPU.
//   clk, rstreq            : clock, asynchronous active-low reset
//   ld_start, ld_done      : load session open / close pulses
//   ewr, ead, edat         : loader write port
//   cpu_req ... cpu_halt   : CPU memory request side and halt level
//   cpu_gnt                : CPU request accepted this cycle
//   cpu_rvalid, cpu_rdata  : read response, one cycle after a granted read
//   cpu_rst_n              : registered CPU reset, active-low
//   mem_we/addr/wdata      : memory port, mem_rdata is the 1-cycle sync read
//   state_o                : current FSM state
//   wr_count               : loader writes accepted in current/last session
// -----------------------------------------------------------------------------
module mem_boot_arbiter
    import mem_boot_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int HOLD_CYC = 4
) (
    input  logic          clk,
    input  logic          rstreq,
    input  logic          ld_start,
    input  logic          ld_done,
    input  logic          ewr,
    input  logic [AW-1:0] ead,
    input  logic [DW-1:0] edat,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halt,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rst_n,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    state_o,
    output logic [AW:0]   wr_count
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYC - 1);
    localparam logic [AW:0]           CNT_SAT   = {(AW+1){1'b1}};

    state_t                state;
    state_t                state_nxt;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [AW:0]           wr_count_q;
    logic                  rst_n_q;
    logic                  rvalid_q;
    logic [DW-1:0]         rdata_q;
    logic                  ld_wr;

    mem_port_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .state     (state),
        .ewr       (ewr),
        .ead       (ead),
        .edat      (edat),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_halt  (cpu_halt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_gnt   (cpu_gnt),
        .ld_wr     (ld_wr)
    );

    // ld_start overrides everything else (including ld_done in the same
    // cycle) and always (re)opens a session.
    always_comb begin
        state_nxt = state;
        if (ld_start) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: if (ld_done) state_nxt = ST_HOLD;
                ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
                ST_RUN:  if (cpu_halt) state_nxt = ST_HALT;
                ST_HALT: ;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstreq) begin
        if (!rstreq) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            wr_count_q <= '0;
            rst_n_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state <= state_nxt;

            // Counts HOLD cycles; starts from zero on every HOLD entry.
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if (ld_start) begin
                wr_count_q <= '0;
            end else if (ld_wr && (wr_count_q != CNT_SAT)) begin
                wr_count_q <= wr_count_q + 1'b1;
            end

            // Registered from the next state so the CPU leaves reset on the
            // first RUN cycle and re-enters it on the first LOAD cycle.
            rst_n_q <= (state_nxt == ST_RUN) || (state_nxt == ST_HALT);

            rvalid_q <= cpu_gnt & ~cpu_we;
            if (rvalid_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // The memory already registers the read, so during the rvalid cycle the
    // data is passed straight through; rdata_q keeps it stable afterwards.
    assign cpu_rdata  = rvalid_q ? mem_rdata : rdata_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rst_n  = rst_n_q;
    assign state_o    = state;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_boot_arbiter
// Drives mem_boot_arbiter with directed and randomized traffic. A behavioural
// model (phase, hold delay, write count, memory image) predicts every cycle;
// read responses are predicted into a queue and checked by a monitor.
// -----------------------------------------------------------------------------
module tb_mem_boot_arbiter;

    localparam int AW       = 5;
    localparam int DW       = 8;
    localparam int HOLD_CYC = 4;
    localparam int CNT_MAX  = (1 << (AW + 1)) - 1;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_HOLD = 2;
    localparam int P_RUN  = 3;
    localparam int P_HALT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstreq;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT ----------------
    logic          ld_start, ld_done, ewr;
    logic [AW-1:0] ead;
    logic [DW-1:0] edat;
    logic          cpu_req, cpu_we, cpu_halt;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid, cpu_rst_n, mem_we;
    logic [DW-1:0] cpu_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    state_o;
    logic [AW:0]   wr_count;

    mem_boot_arbiter #(
        .AW(AW),
        .DW(DW),
        .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk        (clk),
        .rstreq     (rstreq),
        .ld_start   (ld_start),
        .ld_done    (ld_done),
        .ewr        (ewr),
        .ead        (ead),
        .edat       (edat),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_halt   (cpu_halt),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rst_n  (cpu_rst_n),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .state_o    (state_o),
        .wr_count   (wr_count)
    );

    // 32x8 memory with 1-cycle synchronous read; not affected by reset.
    logic [DW-1:0] tb_mem [32];
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    // ---------------- model and scoreboard ----------------
    logic [DW-1:0] ref_mem [32];
    int            m_phase, m_hold, m_count;
    logic          m_rst_n;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_pass = 0;
    int            n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every rvalid must match the oldest predicted read, in the
    // cycle right after its grant.
    always @(negedge clk) begin : monitor
        logic [DW-1:0] d;
        int            c;
        if (rstreq === 1'b1) begin
            if (cpu_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'(cpu_rvalid), 32'(0));
                end else begin
                    d = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("rdata", 32'(cpu_rdata), 32'(d));
                    check("rvalid_latency", 32'(cyc), 32'(c));
                end
            end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                check("missing_rvalid", 32'(cpu_rvalid), 32'(1));
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One clock cycle: check registered outputs against the model, apply
    // inputs, check combinational outputs, then advance the model.
    task automatic step(input logic e, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input logic rq, input logic we, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic h, input logic ls,
                        input logic ld, output logic g);
        logic lw;
        @(negedge clk);
        check("state", 32'(state_o), 32'(m_phase));
        check("cpu_rst_n", 32'(cpu_rst_n), 32'(m_rst_n));
        check("wr_count", 32'(wr_count), 32'(m_count));
        ewr = e; ead = ea; edat = ed;
        cpu_req = rq; cpu_we = we; cpu_addr = ca; cpu_wdata = cd; cpu_halt = h;
        ld_start = ls; ld_done = ld;
        #1;
        lw = e && (m_phase == P_LOAD || m_phase == P_RUN || m_phase == P_HALT);
        g  = (m_phase == P_RUN) && !e && rq && !h;
        check("cpu_gnt", 32'(cpu_gnt), 32'(g));
        if (lw) begin
            check("mem_we_ld", 32'(mem_we), 32'(1));
            check("mem_addr_ld", 32'(mem_addr), 32'(ea));
            check("mem_wdata_ld", 32'(mem_wdata), 32'(ed));
        end else if (g) begin
            check("mem_we_cpu", 32'(mem_we), 32'(we));
            check("mem_addr_cpu", 32'(mem_addr), 32'(ca));
            if (we) check("mem_wdata_cpu", 32'(mem_wdata), 32'(cd));
        end else if (m_phase == P_RUN) begin
            check("mem_we_nogrant", 32'(mem_we), 32'(0));
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'(0));
            check("mem_addr_idle", 32'(mem_addr), 32'(0));
            check("mem_wdata_idle", 32'(mem_wdata), 32'(0));
        end
        if (lw) begin
            ref_mem[ea] = ed;
            if (m_count < CNT_MAX) m_count++;
        end
        if (g) begin
            if (we) ref_mem[ca] = cd;
            else begin
                exp_q.push_back(ref_mem[ca]);
                exp_cyc_q.push_back(cyc + 1);
            end
        end
        if (ls) begin
            m_phase = P_LOAD;
            m_count = 0;
        end else begin
            case (m_phase)
                P_LOAD: if (ld) begin m_phase = P_HOLD; m_hold = HOLD_CYC; end
                P_HOLD: begin m_hold--; if (m_hold == 0) m_phase = P_RUN; end
                P_RUN:  if (h) m_phase = P_HALT;
                default: ;
            endcase
        end
        m_rst_n = (m_phase == P_RUN) || (m_phase == P_HALT);
    endtask

    task automatic idle(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    endtask

    task automatic pulse(input logic ls, input logic ld);
        logic g;
        step(0, 0, 0, 0, 0, 0, 0, 0, ls, ld, g);
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic g;
        step(1, a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 0, 0, 0, g);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        logic g;
        step(0, 0, 0, 1, 0, a, 0, 0, 0, 0, g);
    endtask

    task automatic check_reset_outputs();
        check("rst_state", 32'(state_o), 32'(P_IDLE));
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'(0));
        check("rst_cpu_gnt", 32'(cpu_gnt), 32'(0));
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'(0));
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_wr_count", 32'(wr_count), 32'(0));
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_hold  = 0;
        m_count = 0;
        m_rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // Assert reset between clock edges and check outputs without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        rstreq = 1'b0;
        ewr = 0; cpu_req = 0; cpu_we = 0; cpu_halt = 0; ld_start = 0; ld_done = 0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstreq = 1'b1;
    endtask

    // Randomized RUN/HALT traffic; the CPU holds a denied request until granted.
    task automatic traffic(input int n, input logic halt_en);
        logic          p_req = 1'b0;
        logic          p_we = 1'b0;
        logic [AW-1:0] p_addr = '0;
        logic [DW-1:0] p_wd = '0;
        logic          g;
        for (int i = 0; i < n; i++) begin
            if (!p_req && $urandom_range(0, 2) != 0) begin
                p_req  = 1'b1;
                p_we   = 1'($urandom_range(0, 1));
                p_addr = 5'($urandom_range(0, 31));
                p_wd   = 8'($urandom_range(0, 255));
            end
            step($urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                 p_req, p_we, p_addr, p_wd, halt_en && ($urandom_range(0, 49) == 0),
                 0, $urandom_range(0, 15) == 0, g);
            if (g) p_req = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic g;
        rstreq = 1'b0;
        ld_start = 0; ld_done = 0; ewr = 0; ead = '0; edat = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_halt = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rstreq = 1'b1;

        // Session 1: full image, addr ^ 8'hA5.
        pulse(1, 0);
        for (int i = 0; i < 32; i++) ld_write(5'(i), 8'(i) ^ 8'hA5);
        pulse(0, 1);
        step(1, 7, 8'hFF, 0, 0, 0, 0, 0, 0, 0, g);  // ignored in HOLD
        idle(HOLD_CYC);                             // last one lands in RUN

        cpu_read(5);                                // expects 8'hA0
        cpu_read(10);
        cpu_read(20);
        cpu_read(31);
        idle(2);

        // Loader and CPU write the same address in one cycle: loader first.
        step(1, 3, 8'h11, 1, 1, 3, 8'h22, 0, 0, 0, g);
        step(0, 0, 0, 1, 1, 3, 8'h22, 0, 0, 0, g);
        cpu_read(3);
        idle(2);

        traffic(300, 1'b0);
        idle(2);

        // Halt, then reload from HALT.
        step(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, g);
        for (int i = 0; i < 6; i++)
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)),
                 1, 0, 5'($urandom_range(0, 31)), 0, 1'($urandom_range(0, 1)), 0, 0, g);
        pulse(1, 0);

        // Session 2: restart, write with ld_done, reset mid-HOLD and mid-LOAD.
        for (int i = 0; i < 5; i++) ld_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        step(1, 9, 8'h5A, 0, 0, 0, 0, 0, 1, 0, g);
        for (int i = 0; i < 3; i++) ld_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        step(1, 12, 8'hC3, 0, 0, 0, 0, 0, 0, 1, g);
        step(1, 13, 8'h3C, 0, 0, 0, 0, 0, 0, 0, g);
        idle(1);
        do_reset();
        pulse(1, 0);
        for (int i = 0; i < 3; i++) ld_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        do_reset();

        // Session 3: start+done together, saturation, reload with a read in flight.
        pulse(1, 0);
        pulse(1, 1);
        for (int i = 0; i < 70; i++) ld_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
        pulse(0, 1);
        idle(HOLD_CYC + 1);
        cpu_read(2);
        pulse(1, 0);
        ld_write(4, 8'h44);
        pulse(0, 1);
        idle(HOLD_CYC + 1);
        traffic(250, 1'b1);
        idle(3);

        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        for (int i = 0; i < 32; i++) check("mem_image", 32'(tb_mem[i]), 32'(ref_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_boot_arbiter.md
Name: mem_boot_arbiter

Overview:
Sequences CPU boot and shares the 32x8 program/data memory between the external loader port (ewr/ead/edat) and the CPU core. It holds the CPU in reset while a program image is written, releases it after a programmable hold delay, and arbitrates memory access during run with fixed loader priority. It sits between the top-level pins and the memory instance inside the CPU top module.

Parameters:
AW, 5, memory address width (32 locations)
DW, 8, memory data width
HOLD_CYC, 4, cycles cpu_rst_n stays low after ld_done (range 1..15)

Ports:
clk  input  1  system clock, rising edge
rstreq  input  1  asynchronous active-low reset
ld_start  input  1  pulse; opens a load session
ld_done  input  1  pulse; closes a load session
ewr  input  1  loader write strobe
ead  input  AW  loader write address
edat  input  DW  loader write data
cpu_req  input  1  CPU memory request
cpu_we  input  1  CPU write (1) / read (0)
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_halt  input  1  CPU halted (level)
cpu_gnt  output  1  CPU request accepted this cycle
cpu_rvalid  output  1  read data valid
cpu_rdata  output  DW  read data
cpu_rst_n  output  1  CPU reset, active-low
mem_we  output  1  memory write enable
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, 1-cycle synchronous read
state_o  output  3  current FSM state
wr_count  output  AW+1  loader writes accepted in current/last session

Behaviour:
- Reset (rstreq=0, async): state=IDLE, cpu_rst_n=0, cpu_gnt=0, cpu_rvalid=0, cpu_rdata=0, mem_we=0, wr_count=0, hold counter=0.
- States: IDLE(0), LOAD(1), HOLD(2), RUN(3), HALT(4).
- IDLE: ld_start -> LOAD. cpu_rst_n=0.
- LOAD: cpu_rst_n=0; wr_count cleared on entry. Each ewr cycle drives mem_we=1, mem_addr=ead, mem_wdata=edat combinationally; wr_count increments and saturates at 2^(AW+1)-1. ld_done -> HOLD. If ewr and ld_done occur together, the write is still performed and counted.
- HOLD: counter counts HOLD_CYC cycles with cpu_rst_n=0, then -> RUN. cpu_rst_n is registered and goes high on the first RUN cycle. ewr is ignored, with no write and no count.
- RUN: cpu_rst_n=1.
  - Arbitration per cycle: ewr wins, so the loader writes and cpu_gnt=0.
  - Otherwise cpu_gnt=cpu_req and mem_* follow cpu_* (mem_we=cpu_req&cpu_we).
  - A denied CPU request must be held by the CPU until granted.
  - Loader writes in RUN also increment wr_count.
- Read latency: a granted read asserts cpu_rvalid exactly 1 cycle later, with cpu_rdata=mem_rdata registered in that cycle. Writes produce no rvalid. Back-to-back reads give rvalid every cycle.
- RUN with cpu_halt=1 -> HALT; any grant in that same cycle is suppressed. HALT keeps cpu_rst_n=1, grants nothing and permits loader writes.
- ld_start in RUN or HALT -> LOAD; cpu_rst_n drops to 0 the next cycle. A pending rvalid still completes.
- ld_start in LOAD restarts the session (wr_count cleared). ld_start in HOLD -> LOAD.
- ld_done outside LOAD is ignored. ld_start and ld_done together: ld_start wins.
- Reset asserted mid-operation returns to IDLE immediately; memory contents are untouched.
- In idle states mem_we=0 and mem_addr/mem_wdata=0.

Decomposition:
- Shared package: state enum (IDLE..HALT, 3 bits), AW/DW defaults, HOLD_CYC max constant.
- One natural sub-module: mem_port_mux, the combinational loader/CPU select producing mem_* and cpu_gnt from state and requests.
- FSM, counters and the read-valid pipeline stay in the top block.

Test Plan:
- Reset then ld_start, 32 ewr writes (ead=0..31, edat=addr^8'hA5), ld_done -> mem writes match, wr_count=32, cpu_rst_n stays 0 until exactly HOLD_CYC=4 cycles after HOLD entry, then state=RUN.
- RUN, cpu_req read addr 5 -> cpu_gnt=1 the same cycle, cpu_rvalid=1 next cycle with cpu_rdata=8'hA0; three back-to-back reads -> three consecutive rvalids.
- RUN, ewr and cpu_req write in the same cycle (ead=3, edat=8'h11; cpu_addr=3, 8'h22) -> cpu_gnt=0, mem gets 8'h11; CPU retries next cycle and mem gets 8'h22.
- RUN, cpu_halt=1 -> state=HALT, no further grants; ld_start -> LOAD, cpu_rst_n=0 next cycle, wr_count=0.
- Reset (rstreq=0) asserted mid-HOLD and mid-LOAD -> outputs return to reset values asynchronously, state=IDLE.
- ewr with ld_done in the same cycle -> write performed, wr_count incremented, state=HOLD; ewr during HOLD -> mem_we=0, count unchanged.
